// File: rtl/mem_wait_responder_pkg.sv
// Shared types and elaboration helpers for the mem_* wait-state responder.
package mem_wait_responder_pkg;

  localparam int DEFAULT_MADDR_WIDTH = 64;
  localparam int DEFAULT_MDATA_WIDTH = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_RD = 3'd1,
    WAIT_WR = 3'd2,
    DONE_RD = 3'd3,
    DONE_WR = 3'd4
  } mem_state_e;

  // Byte stride of one stored word; narrow buses still advance one byte per word.
  function automatic int word_bytes(input int maddr_width);
    return ((maddr_width / 8) > 0) ? (maddr_width / 8) : 1;
  endfunction

  function automatic int wait_cnt_width(input int rd_wait, input int wr_wait);
    int m;
    m = (rd_wait > wr_wait) ? rd_wait : wr_wait;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/mem_wait_responder_if.sv
// mem_* read/write handshake bundle between an initiator and the memory responder.
interface mem_wait_responder_if
  import mem_wait_responder_pkg::*;
#(
  parameter int MADDR_WIDTH = DEFAULT_MADDR_WIDTH,
  parameter int MDATA_WIDTH = DEFAULT_MDATA_WIDTH
);

  logic                   mem_read_enable;
  logic                   mem_write_enable;
  logic                   mem_write_ready;
  logic                   mem_read_ready;
  logic [MADDR_WIDTH-1:0] mem_addr;
  logic [MDATA_WIDTH-1:0] mem_read_data;
  logic [MDATA_WIDTH-1:0] mem_write_data;
  logic                   mem_error;

  modport master (
    output mem_read_enable, mem_write_enable, mem_addr, mem_write_data,
    input  mem_write_ready, mem_read_ready, mem_read_data, mem_error
  );

  modport slave (
    input  mem_read_enable, mem_write_enable, mem_addr, mem_write_data,
    output mem_write_ready, mem_read_ready, mem_read_data, mem_error
  );

endinterface

// File: rtl/mem_wait_responder_word_array.sv
// Single-port synchronous word store: one write port with enable, registered read of the same address.
module mem_wait_responder_word_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic                  clock,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Contents are deliberately never reset; read is read-first on a same-address write.
  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_wait_responder.sv
// Latency-configurable memory responder: one outstanding read or write, programmable wait states,
// ready held until the initiator drops its enable, sticky error for out-of-range or collided requests.
module mem_wait_responder
  import mem_wait_responder_pkg::*;
#(
  parameter int MADDR_WIDTH = DEFAULT_MADDR_WIDTH,
  parameter int MDATA_WIDTH = DEFAULT_MDATA_WIDTH,
  parameter int DEPTH_WORDS = 1024,
  parameter int READ_WAIT   = 2,
  parameter int WRITE_WAIT  = 1
) (
  input logic                 clock,
  input logic                 reset,
  mem_wait_responder_if.slave bus
);

  localparam int WB = word_bytes(MADDR_WIDTH);
  localparam int CW = wait_cnt_width(READ_WAIT, WRITE_WAIT);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [CW-1:0]          RD_LOAD  = CW'(READ_WAIT - 1);
  localparam logic [CW-1:0]          WR_LOAD  = CW'(WRITE_WAIT - 1);
  localparam logic [CW-1:0]          CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0]          CNT_ZERO = {CW{1'b0}};
  localparam logic [MADDR_WIDTH-1:0] WB_A     = MADDR_WIDTH'(WB);
  localparam logic [MADDR_WIDTH-1:0] DEPTH_A  = MADDR_WIDTH'(DEPTH_WORDS);

  mem_state_e             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic [MDATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                   oor_q, oor_d;
  logic                   wr_rdy_q, wr_rdy_d;
  logic                   rd_rdy_q, rd_rdy_d;
  logic                   err_q, err_d;

  logic                   rd_en_s;
  logic                   wr_en_s;
  logic [MADDR_WIDTH-1:0] req_idx_s;
  logic                   req_oor_s;
  logic                   arr_we_s;
  logic [MDATA_WIDTH-1:0] arr_rdata_s;

  // Only a clean logic 1 counts as a request; z/x from an undriven bus stays idle.
  assign rd_en_s   = (bus.mem_read_enable === 1'b1);
  assign wr_en_s   = (bus.mem_write_enable === 1'b1);
  assign req_idx_s = bus.mem_addr / WB_A;
  assign req_oor_s = (req_idx_s >= DEPTH_A);

  // Next-state, counter, request latch and array write strobe.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    oor_d    = oor_q;
    wr_rdy_d = 1'b0;
    rd_rdy_d = 1'b0;
    err_d    = err_q;
    arr_we_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_en_s) begin
          state_d = WAIT_WR;
          cnt_d   = WR_LOAD;
          idx_d   = req_idx_s[AW-1:0];
          wdata_d = bus.mem_write_data;
          oor_d   = req_oor_s;
          err_d   = err_q | req_oor_s | rd_en_s;
        end else if (rd_en_s) begin
          state_d = WAIT_RD;
          cnt_d   = RD_LOAD;
          idx_d   = req_idx_s[AW-1:0];
          oor_d   = req_oor_s;
          err_d   = err_q | req_oor_s;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_WR: begin
        if (!wr_en_s) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_ZERO) begin
          state_d  = DONE_WR;
          wr_rdy_d = 1'b1;
          arr_we_s = !oor_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      WAIT_RD: begin
        if (!rd_en_s) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_ZERO) begin
          state_d  = DONE_RD;
          rd_rdy_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DONE_WR: begin
        if (wr_en_s) begin
          wr_rdy_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      DONE_RD: begin
        if (rd_en_s) begin
          rd_rdy_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= CNT_ZERO;
      idx_q    <= {AW{1'b0}};
      wdata_q  <= {MDATA_WIDTH{1'b0}};
      oor_q    <= 1'b0;
      wr_rdy_q <= 1'b0;
      rd_rdy_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      oor_q    <= oor_d;
      wr_rdy_q <= wr_rdy_d;
      rd_rdy_q <= rd_rdy_d;
      err_q    <= err_d;
    end
  end

  // The array re-reads the latched index every cycle, so its output is current on entry to DONE_RD.
  mem_wait_responder_word_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .DATA_WIDTH (MDATA_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_array (
    .clock  (clock),
    .we_i   (arr_we_s),
    .addr_i (idx_q),
    .wdata_i(wdata_q),
    .rdata_o(arr_rdata_s)
  );

  assign bus.mem_write_ready = wr_rdy_q;
  assign bus.mem_read_ready  = rd_rdy_q;
  assign bus.mem_error       = err_q;
  assign bus.mem_read_data   = (rd_rdy_q && !oor_q) ? arr_rdata_s : {MDATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_mem_wait_responder.sv
// Randomized bench for mem_wait_responder against a transaction-level memory model.
module tb_mem_wait_responder;

  localparam int AWB   = 64;
  localparam int DWB   = 64;
  localparam int DEPTH = 1024;
  localparam int RW    = 2;
  localparam int WW    = 3;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  mem_wait_responder_if #(.MADDR_WIDTH(AWB), .MDATA_WIDTH(DWB)) bus_if ();

  mem_wait_responder #(
    .MADDR_WIDTH(AWB),
    .MDATA_WIDTH(DWB),
    .DEPTH_WORDS(DEPTH),
    .READ_WAIT  (RW),
    .WRITE_WAIT (WW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus_if)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] ref_mem [int];
  logic        ref_err;
  int          written[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus_if.mem_read_enable  = 1'b0;
    bus_if.mem_write_enable = 1'b0;
    bus_if.mem_addr         = {$urandom, $urandom};
    bus_if.mem_write_data   = {$urandom, $urandom};
  endtask

  // One full write handshake; model is updated from the address/index rules.
  task automatic bus_write(input logic [63:0] addr, input logic [63:0] data,
                           input bit with_read, input int hold);
    logic [63:0] widx;
    bit          oor;
    int          lat;
    bit          bad_other;
    bit          bad_hold;
    widx = addr / 64'd8;
    oor  = (widx >= 64'(DEPTH));
    @(negedge clock);
    bus_if.mem_write_enable = 1'b1;
    bus_if.mem_read_enable  = with_read;
    bus_if.mem_addr         = addr;
    bus_if.mem_write_data   = data;
    lat = 0; bad_other = 1'b0; bad_hold = 1'b0;
    while (lat < 20) begin
      @(negedge clock);
      lat++;
      bus_if.mem_addr       = {$urandom, $urandom};
      bus_if.mem_write_data = {$urandom, $urandom};
      if (bus_if.mem_read_ready) bad_other = 1'b1;
      if (bus_if.mem_write_ready) break;
    end
    check_val("wr_latency", 64'(lat), 64'(WW + 1));
    repeat (hold) begin
      @(negedge clock);
      if (!bus_if.mem_write_ready || bus_if.mem_read_ready) bad_hold = 1'b1;
    end
    drive_idle();
    @(negedge clock);
    check_val("wr_ready_drop", 64'(bus_if.mem_write_ready), 64'd0);
    check_val("wr_hold", 64'(bad_hold), 64'd0);
    check_val("wr_no_rd_ready", 64'(bad_other), 64'd0);
    if (!oor) begin
      ref_mem[int'(widx)] = data;
      written.push_back(int'(widx));
    end
    ref_err = ref_err | oor | with_read;
    check_val("wr_error", 64'(bus_if.mem_error), 64'(ref_err));
  endtask

  // One full read handshake checked against the model.
  task automatic bus_read(input logic [63:0] addr, input int hold);
    logic [63:0] widx;
    bit          oor;
    logic [63:0] exp;
    int          lat;
    bit          bad_wait;
    bit          bad_other;
    bit          bad_hold;
    widx = addr / 64'd8;
    oor  = (widx >= 64'(DEPTH));
    exp  = oor ? 64'd0 : ref_mem[int'(widx)];
    @(negedge clock);
    bus_if.mem_read_enable  = 1'b1;
    bus_if.mem_write_enable = 1'b0;
    bus_if.mem_addr         = addr;
    lat = 0; bad_wait = 1'b0; bad_other = 1'b0; bad_hold = 1'b0;
    while (lat < 20) begin
      @(negedge clock);
      lat++;
      bus_if.mem_addr = {$urandom, $urandom};
      if (bus_if.mem_write_ready) bad_other = 1'b1;
      if (bus_if.mem_read_ready) break;
      if (bus_if.mem_read_data !== 64'd0) bad_wait = 1'b1;
    end
    check_val("rd_latency", 64'(lat), 64'(RW + 1));
    check_val("rd_data", bus_if.mem_read_data, exp);
    repeat (hold) begin
      @(negedge clock);
      if (!bus_if.mem_read_ready || bus_if.mem_read_data !== exp) bad_hold = 1'b1;
    end
    drive_idle();
    @(negedge clock);
    check_val("rd_ready_drop", 64'(bus_if.mem_read_ready), 64'd0);
    check_val("rd_data_drop", bus_if.mem_read_data, 64'd0);
    check_val("rd_data_zero_wait", 64'(bad_wait), 64'd0);
    check_val("rd_hold", 64'(bad_hold), 64'd0);
    check_val("rd_no_wr_ready", 64'(bad_other), 64'd0);
    if (oor) ref_err = 1'b1;
    check_val("rd_error", 64'(bus_if.mem_error), 64'(ref_err));
  endtask

  // Write that is abandoned mid-wait, by dropping enable or by reset.
  task automatic bus_write_abort(input logic [63:0] addr, input logic [63:0] data,
                                 input int wait_cyc, input bit use_reset);
    bit bad_rdy;
    @(negedge clock);
    bus_if.mem_write_enable = 1'b1;
    bus_if.mem_read_enable  = 1'b0;
    bus_if.mem_addr         = addr;
    bus_if.mem_write_data   = data;
    repeat (wait_cyc) @(negedge clock);
    drive_idle();
    if (use_reset) begin
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      ref_err = 1'b0;
    end
    bad_rdy = 1'b0;
    repeat (WW + 3) begin
      @(negedge clock);
      if (bus_if.mem_write_ready || bus_if.mem_read_ready) bad_rdy = 1'b1;
    end
    check_val(use_reset ? "rst_abort_ready" : "abort_ready", 64'(bad_rdy), 64'd0);
    check_val(use_reset ? "rst_abort_error" : "abort_error", 64'(bus_if.mem_error), 64'(ref_err));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [63:0] a;
    int          r;
    ref_err = 1'b0;
    reset   = 1'b0;
    drive_idle();
    repeat (2) @(negedge clock);
    check_val("reset_wr_ready", 64'(bus_if.mem_write_ready), 64'd0);
    check_val("reset_rd_ready", 64'(bus_if.mem_read_ready), 64'd0);
    check_val("reset_rd_data", bus_if.mem_read_data, 64'd0);
    check_val("reset_error", 64'(bus_if.mem_error), 64'd0);
    reset = 1'b1;

    bus_write(64'h10, 64'd7, 1'b0, 2);
    bus_read(64'h10, 1);
    bus_write(64'h0, 64'h0123_4567_89ab_cdef, 1'b0, 0);
    bus_write(64'h20, 64'd11, 1'b0, 0);

    bus_write_abort(64'h20, 64'd3, 1, 1'b0);
    bus_write_abort(64'h24, 64'd3, 2, 1'b0);
    bus_read(64'h20, 0);

    bus_write(64'h18, 64'd9, 1'b1, 1);
    bus_read(64'h18, 0);

    bus_write(64'(DEPTH) * 64'd8, 64'd5, 1'b0, 0);
    bus_read(64'h0, 0);
    bus_read(64'(DEPTH) * 64'd8, 1);

    bus_write_abort(64'h20, 64'd3, 1, 1'b1);
    check_val("rst_rd_data", bus_if.mem_read_data, 64'd0);
    bus_read(64'h20, 0);

    for (int i = 0; i < 72; i++) begin
      bus_write(64'h1000 + 64'(i) * 64'd8, {$urandom, $urandom}, 1'b0, $urandom_range(2, 0));
      repeat ($urandom_range(2, 0)) @(negedge clock);
    end
    for (int i = 0; i < 72; i++) begin
      bus_read(64'h1000 + 64'(i) * 64'd8, $urandom_range(1, 0));
    end

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(9, 0);
      if (r < 4) begin
        a = 64'($urandom_range(DEPTH - 1, 0)) * 64'd8 + 64'($urandom_range(7, 0));
        bus_write(a, {$urandom, $urandom}, 1'b0, $urandom_range(2, 0));
      end else if (r < 8) begin
        a = 64'(written[$urandom_range(written.size() - 1, 0)]) * 64'd8 + 64'($urandom_range(7, 0));
        bus_read(a, $urandom_range(2, 0));
      end else if (r == 8) begin
        a = 64'(DEPTH + $urandom_range(200, 0)) * 64'd8;
        bus_write(a, {$urandom, $urandom}, 1'b0, 0);
      end else begin
        a = {$urandom | 32'd1, $urandom};
        bus_read(a, 0);
      end
      repeat ($urandom_range(2, 0)) @(negedge clock);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
